muladd_mac: RTL and testbench

//   Parametrised multiply-add / multiply-accumulate unit with ready/valid on both sides.

---
 rtl/muladd_pkg.sv | 16 +
 rtl/mul_iter.sv | 50 +++++
 rtl/muladd_mac.sv | 107 ++++++++++
 tb/tb_muladd_mac.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muladd_pkg.sv
// Shared types for the multiply-add / multiply-accumulate unit.
package muladd_pkg;

   typedef enum logic {
      MODE_MULADD = 1'b0,
      MODE_MAC    = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2,
      OUT  = 2'd3
   } macstate_e;

endpackage

// File: rtl/mul_iter.sv
// Bit-serial shift-add multiplier: one multiplier bit per cycle, LSB first,
// exactly WIDTH cycles per product after a start pulse.
module mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= {{WIDTH{1'b0}}, a_i};
         mplier_q <= b_i;
         prod_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) prod_q <= prod_q + mcand_q;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
         if (cnt_q == LAST) busy_q <= 1'b0;
      end
   end

   // done is raised during the last bit cycle so the product is final on the next edge
   assign done_o    = busy_q && (cnt_q == LAST);
   assign product_o = prod_q;

endmodule

// File: rtl/muladd_mac.sv
// Multiply-add (a*b+c) / multiply-accumulate (acc+a*b) unit with a serial
// multiplier, zero-operand skip and optional unsigned saturation.
module muladd_mac
   import muladd_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   output logic             in_ready_o,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   input  logic             mode_i,
   input  logic             acc_clr_i,
   output logic [WIDTH-1:0] prodsum_o,
   output logic             ovf_o,
   output logic             prodsum_valid_o,
   input  logic             prodsum_ready_i,
   output macstate_e        state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both
   // high; valid never waits on ready, and a valid result holds its data until taken.

   macstate_e          state_q, state_d;
   logic               accept, op_zero, mul_start, mul_done;
   logic [2*WIDTH-1:0] mul_product, product;
   logic [2*WIDTH:0]   sum;
   logic               sum_ovf;
   logic [WIDTH-1:0]   sat_result;

   mode_e              mode_q;
   logic               zero_q;
   logic [WIDTH-1:0]   addend_q, acc_q, result_q;
   logic               ovf_q;

   assign op_zero = (a_i == '0) || (b_i == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = op_zero ? ADD : MUL;
         MUL:  if (mul_done) state_d = ADD;
         ADD:  state_d = OUT;
         OUT:  if (prodsum_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready_o      = (state_q == IDLE) && rst_ni;
      prodsum_valid_o = (state_q == OUT);
      accept          = in_valid_i && in_ready_o;
      mul_start       = accept && !op_zero;
   end

   mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (mul_start),
      .a_i       (a_i),
      .b_i       (b_i),
      .done_o    (mul_done),
      .product_o (mul_product)
   );

   // Skipped multiplications leave the multiplier's stale product behind, so mask it
   assign product    = zero_q ? '0 : mul_product;
   assign sum        = {1'b0, product} + {{(WIDTH + 1){1'b0}}, addend_q};
   assign sum_ovf    = |sum[2*WIDTH:WIDTH];
   assign sat_result = (SATURATE && sum_ovf) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q   <= MODE_MULADD;
         zero_q   <= 1'b0;
         addend_q <= '0;
         acc_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (accept) begin
            mode_q   <= mode_e'(mode_i);
            zero_q   <= op_zero;
            addend_q <= (mode_e'(mode_i) == MODE_MAC && !acc_clr_i) ? acc_q : c_i;
         end
         if (state_q == ADD) begin
            result_q <= sat_result;
            ovf_q    <= sum_ovf;
         end
         if (state_q == OUT && prodsum_ready_i && mode_q == MODE_MAC) acc_q <= result_q;
      end
   end

   assign prodsum_o = result_q;
   assign ovf_o     = ovf_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_muladd_mac.sv
// Bench for muladd_mac: wrap and saturate builds side by side, driven identically.
module tb_muladd_mac;
   import muladd_pkg::*;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] res0;
      logic [W-1:0] res1;
      logic         ovf0;
      logic         ovf1;
      logic         mac;
      int           first_cyc;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic         in_valid = 1'b0;
   logic [W-1:0] a = '0, b = '0, c = '0;
   logic         mode = 1'b0, acc_clr = 1'b0, prodsum_ready = 1'b1;

   logic         in_ready0, in_ready1, valid0, valid1, ovf0, ovf1;
   logic [W-1:0] ps0, ps1;
   macstate_e    st0, st1;

   muladd_mac #(.WIDTH(W), .SATURATE(1'b0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .in_ready_o(in_ready0), .in_valid_i(in_valid),
      .a_i(a), .b_i(b), .c_i(c), .mode_i(mode), .acc_clr_i(acc_clr),
      .prodsum_o(ps0), .ovf_o(ovf0), .prodsum_valid_o(valid0),
      .prodsum_ready_i(prodsum_ready), .state_o(st0)
   );

   muladd_mac #(.WIDTH(W), .SATURATE(1'b1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .in_ready_o(in_ready1), .in_valid_i(in_valid),
      .a_i(a), .b_i(b), .c_i(c), .mode_i(mode), .acc_clr_i(acc_clr),
      .prodsum_o(ps1), .ovf_o(ovf1), .prodsum_valid_o(valid1),
      .prodsum_ready_i(prodsum_ready), .state_o(st1)
   );

   // ---------------- scoreboard state ----------------
   exp_t         exp_q[$];
   logic [W-1:0] acc_m[2];
   bit           seen;
   int           checks = 0;
   int           passes = 0;
   int           last_accept_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference arithmetic: exact unsigned sum, then wrap or clamp.
   function automatic logic [W:0] expect_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] addend, input bit sat);
      longint       exact;
      logic         ovf;
      logic [W-1:0] lo;
      exact = longint'(x) * longint'(y) + longint'(addend);
      ovf   = exact > longint'(2**W - 1);
      lo    = exact[W-1:0];
      return {ovf, (sat && ovf) ? {W{1'b1}} : lo};
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         seen     = 1'b0;
         acc_m[0] = '0;
         acc_m[1] = '0;
      end else begin
         check("valid_match", valid1, valid0);
         if (exp_q.size() > 0 && !seen) begin
            if (valid0) begin
               check("latency", cyc, exp_q[0].first_cyc);
               seen = 1'b1;
            end else if (cyc >= exp_q[0].first_cyc) begin
               check("latency_valid", valid0, 1'b1);
               seen = 1'b1;
            end
         end
         if (valid0) begin
            check("pending_op", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               check("res_wrap", ps0, exp_q[0].res0);
               check("ovf_wrap", ovf0, exp_q[0].ovf0);
               check("res_sat", ps1, exp_q[0].res1);
               check("ovf_sat", ovf1, exp_q[0].ovf1);
               if (prodsum_ready) begin
                  if (exp_q[0].mac) begin
                     acc_m[0] = exp_q[0].res0;
                     acc_m[1] = exp_q[0].res1;
                  end
                  void'(exp_q.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                        input logic m, input logic clr);
      int           n;
      exp_t         e;
      logic [W-1:0] ad0, ad1;
      logic [W:0]   r0, r1;
      n = 0;
      while (!in_ready0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready0) begin
         check("ready_timeout", in_ready0, 1'b1);
         return;
      end
      a = x; b = y; c = z; mode = m; acc_clr = clr; in_valid = 1'b1;
      ad0 = (m && !clr) ? acc_m[0] : z;
      ad1 = (m && !clr) ? acc_m[1] : z;
      r0  = expect_res(x, y, ad0, 1'b0);
      r1  = expect_res(x, y, ad1, 1'b1);
      e.res0 = r0[W-1:0]; e.ovf0 = r0[W];
      e.res1 = r1[W-1:0]; e.ovf1 = r1[W];
      e.mac  = m;
      e.first_cyc = cyc + ((x == '0 || y == '0) ? 2 : W + 2);
      exp_q.push_back(e);
      last_accept_cyc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (valid0) break;
      end
      if (!valid0) check("valid_timeout", valid0, 1'b1);
   endtask

   task automatic run_lit(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                          input logic m, input logic clr,
                          input logic [W-1:0] r0, input logic o0,
                          input logic [W-1:0] r1, input logic o1, input int lat);
      int c0;
      do_op(x, y, z, m, clr);
      c0 = last_accept_cyc;
      wait_valid();
      check("lit_latency", cyc - c0, lat);
      check("lit_res_wrap", ps0, r0);
      check("lit_ovf_wrap", ovf0, o0);
      check("lit_res_sat", ps1, r1);
      check("lit_ovf_sat", ovf1, o1);
      @(posedge clk); #1;
   endtask

   task automatic drain(input bit rnd);
      for (int n = 0; n < 400; n++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk); #1;
         if (rnd) prodsum_ready = ($urandom_range(0, 3) != 0);
      end
      prodsum_ready = 1'b1;
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready0, 1'b0);
      check("rst_in_ready_sat", in_ready1, 1'b0);
      check("rst_valid", valid0, 1'b0);
      check("rst_prodsum", ps0, 0);
      check("rst_ovf", ovf0, 1'b0);
      rst_n = 1'b1;
      #1;
      check("rst_state", st0, IDLE);
      check("idle_in_ready", in_ready0, 1'b1);

      // basic, zero skip, overflow
      run_lit(8'd3, 8'd4, 8'd5, MODE_MULADD, 1'b0, 8'd17, 1'b0, 8'd17, 1'b0, 10);
      run_lit(8'd0, 8'd77, 8'd9, MODE_MULADD, 1'b0, 8'd9, 1'b0, 8'd9, 1'b0, 2);
      run_lit(8'd77, 8'd0, 8'd9, MODE_MULADD, 1'b0, 8'd9, 1'b0, 8'd9, 1'b0, 2);
      run_lit(8'd200, 8'd2, 8'd100, MODE_MULADD, 1'b0, 8'd244, 1'b1, 8'd255, 1'b1, 10);
      run_lit(8'd15, 8'd17, 8'd0, MODE_MULADD, 1'b0, 8'd255, 1'b0, 8'd255, 1'b0, 10);

      // accumulator chain; MULADD in between must not disturb it
      run_lit(8'd2, 8'd3, 8'd10, MODE_MAC, 1'b1, 8'd16, 1'b0, 8'd16, 1'b0, 10);
      run_lit(8'd4, 8'd5, 8'd99, MODE_MAC, 1'b0, 8'd36, 1'b0, 8'd36, 1'b0, 10);
      run_lit(8'd1, 8'd1, 8'd1, MODE_MULADD, 1'b0, 8'd2, 1'b0, 8'd2, 1'b0, 10);
      run_lit(8'd1, 8'd1, 8'd0, MODE_MAC, 1'b0, 8'd37, 1'b0, 8'd37, 1'b0, 10);

      // backpressure in OUT with stray input pulses
      prodsum_ready = 1'b0;
      do_op(8'd9, 8'd9, 8'd1, MODE_MULADD, 1'b0);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         in_valid = 1'($urandom_range(0, 1));
         a = W'($urandom_range(1, 255));
         b = W'($urandom_range(1, 255));
         check("bp_in_ready", in_ready0, 1'b0);
         check("bp_valid", valid0, 1'b1);
         check("bp_prodsum", ps0, 8'd82);
      end
      in_valid = 1'b0;
      prodsum_ready = 1'b1;
      @(posedge clk); #1;
      check("ready_after_hs", in_ready0, 1'b1);
      check("state_after_hs", st0, IDLE);
      run_lit(8'd6, 8'd7, 8'd8, MODE_MULADD, 1'b0, 8'd50, 1'b0, 8'd50, 1'b0, 10);

      // reset in the middle of a multiplication
      do_op(8'd5, 8'd7, 8'd0, MODE_MULADD, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", valid0, 1'b0);
      check("midrst_in_ready", in_ready0, 1'b0);
      check("midrst_state", st0, IDLE);
      check("midrst_state_sat", st1, IDLE);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("postrst_state", st0, IDLE);
      check("postrst_in_ready", in_ready0, 1'b1);
      run_lit(8'd1, 8'd1, 8'd50, MODE_MAC, 1'b0, 8'd1, 1'b0, 8'd1, 1'b0, 10);

      // randomized traffic with random consumer stalls
      for (int i = 0; i < 60; i++) begin
         logic [W-1:0] x, y, z;
         x = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(0, 255));
         y = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(0, 255));
         z = W'($urandom_range(0, 255));
         do_op(x, y, z, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
         drain(1'b1);
      end
      drain(1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
